// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcode and FSM state enums plus
// the predicate that tells which opcodes need more than one RUN step.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'd0,
        OP_ADC    = 4'd1,
        OP_SUB    = 4'd2,
        OP_SBC    = 4'd3,
        OP_SHL1   = 4'd4,
        OP_SHR1   = 4'd5,
        OP_NAND   = 4'd6,
        OP_SHLN   = 4'd7,
        OP_SHRN   = 4'd8,
        OP_MUL    = 4'd9,
        OP_CLRC   = 4'd10,
        OP_SETC   = 4'd11,
        OP_RSV12  = 4'd12,
        OP_RSV13  = 4'd13,
        OP_RSV14  = 4'd14,
        OP_RSV15  = 4'd15
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } alu_state_t;

    // Ops whose result is built up over several RUN cycles.
    function automatic logic is_multicycle(input alu_op_t op);
        return (op == OP_SHLN) || (op == OP_SHRN) || (op == OP_MUL);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational single-step datapath: arithmetic, rotate-through-carry,
// NAND and carry set/clear. Multi-cycle and reserved ops yield 0 with the
// carry passed through unchanged.
module alu_core
    import alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [3:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cf_in,
    output logic [W-1:0] rslt,
    output logic         cf_out
);

    // One-step result; every add is W+1 bits so the carry falls out on top.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        rslt   = '0;
        cf_out = cf_in;
        case (alu_op_t'(op))
            OP_ADD:  {cf_out, rslt} = {1'b0, a} + {1'b0, b};
            OP_ADC:  {cf_out, rslt} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cf_in};
            OP_SUB:  {cf_out, rslt} = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
            OP_SBC:  {cf_out, rslt} = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, cf_in};
            OP_SHL1: {cf_out, rslt} = {a, cf_in};
            OP_SHR1: {rslt, cf_out} = {cf_in, a};
            OP_NAND: rslt = ~(a & b);
            OP_CLRC: cf_out = 1'b0;
            OP_SETC: cf_out = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU with valid/ready on both sides. A three-state FSM
// (IDLE/RUN/DONE) latches operands, steps shifts and the shift-add
// multiplier one bit per cycle, and holds registered results in DONE.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int W       = 8,
    parameter int SHAMT_W = $clog2(W)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   op,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] rslt,
    output logic [W-1:0] rslt_hi,
    output logic         cf,
    output logic         zero,
    output logic         pari
);

    // Counter must hold W (MUL step count), one bit wider than a shift amount.
    localparam int CNT_W = SHAMT_W + 1;

    alu_state_t         state;
    alu_op_t            op_in;
    alu_op_t            op_q;
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [W-1:0]       work_lo;
    logic [W-1:0]       work_hi;
    logic [CNT_W-1:0]   cnt;
    logic [SHAMT_W-1:0] in_amt;
    logic               zero_amt;

    logic [W-1:0]       core_rslt;
    logic               core_cf;
    logic [W:0]         mul_sum;
    logic [W-1:0]       step_lo;
    logic [W-1:0]       step_hi;
    logic               step_out;
    logic [W-1:0]       fin_rslt;
    logic [W-1:0]       fin_hi;
    logic               fin_cf;

    assign op_in    = alu_op_t'(op);
    assign in_amt   = in_b[SHAMT_W-1:0];
    assign zero_amt = (b_q[SHAMT_W-1:0] == '0);

    alu_core #(.W(W)) u_core (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .cf_in  (cf),
        .rslt   (core_rslt),
        .cf_out (core_cf)
    );

    // One iteration of the shift or shift-add multiply on the work registers.
    always_comb begin
        mul_sum  = {1'b0, work_hi} + (work_lo[0] ? {1'b0, a_q} : {(W+1){1'b0}});
        step_lo  = work_lo;
        step_hi  = work_hi;
        step_out = 1'b0;
        case (op_q)
            OP_SHLN: begin
                step_lo  = work_lo << 1;
                step_out = work_lo[W-1];
            end
            OP_SHRN: begin
                step_lo  = work_lo >> 1;
                step_out = work_lo[0];
            end
            OP_MUL: begin
                // {hi,lo} holds partial product above the unconsumed multiplier bits.
                step_hi = mul_sum[W:1];
                step_lo = {mul_sum[0], work_lo[W-1:1]};
            end
            default: ;
        endcase
    end

    // Values loaded into the output registers on the final RUN step.
    always_comb begin
        fin_rslt = core_rslt;
        fin_hi   = '0;
        fin_cf   = core_cf;
        case (op_q)
            OP_SHLN, OP_SHRN: begin
                fin_rslt = zero_amt ? a_q : step_lo;
                fin_cf   = zero_amt ? cf  : step_out;
            end
            OP_MUL: begin
                fin_rslt = step_lo;
                fin_hi   = step_hi;
                fin_cf   = |step_hi;
            end
            default: ;
        endcase
    end

    // Control FSM with registered handshake, result and flag outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments; combinational blocks use blocking.
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            rslt      <= '0;
            rslt_hi   <= '0;
            cf        <= 1'b0;
            zero      <= 1'b1;
            pari      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state    <= RUN;
                        in_ready <= 1'b0;
                    end
                end
                RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        rslt      <= fin_rslt;
                        rslt_hi   <= fin_hi;
                        cf        <= fin_cf;
                        zero      <= (fin_rslt == '0) && (fin_hi == '0);
                        pari      <= ^fin_rslt;
                    end
                end
                DONE: begin
                    // An in_valid arriving with out_ready is left for IDLE to take.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Operand latch, step counter and work registers.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers carry no reset; each is written at accept before it is read.
        if (state == IDLE && in_valid) begin
            op_q    <= op_in;
            a_q     <= in_a;
            b_q     <= in_b;
            work_hi <= '0;
            work_lo <= (op_in == OP_MUL) ? in_b : in_a;
            if (op_in == OP_MUL) begin
                cnt <= CNT_W'(W);
            end else if (is_multicycle(op_in) && in_amt != '0) begin
                cnt <= CNT_W'(in_amt);
            end else begin
                cnt <= CNT_W'(1);
            end
        end else if (state == RUN) begin
            work_lo <= step_lo;
            work_hi <= step_hi;
            cnt     <= cnt - 1'b1;
        end
    end

endmodule
